// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry (output reg + skid) valid/ready buffer.
// Optional saturating illegal-op counter on err_cnt, enabled by defining IMM_ERR_CNT_EN.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [5:0]       EXTOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  immout,
    output logic             imm_err
`ifdef IMM_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge.
    logic            accept;
    logic            drain;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic            skid_err;
    logic [XLEN-1:0] new_imm;
    logic            new_err;
    logic            unused_opcode;

    assign unused_opcode = ^instr[6:0];
    assign in_ready      = !skid_valid;
    assign accept        = in_valid && in_ready;
    assign drain         = out_valid && out_ready;

    // Start from the sign fill, then overlay the format's low bits.
    always_comb begin
        new_imm = {XLEN{instr[31]}};
        new_err = 1'b0;
        unique case (EXTOp)
            6'b100000: begin
                new_imm                = '0;
                new_imm[SHAMT_W-1:0]   = instr[20 +: SHAMT_W];
            end
            6'b010000: new_imm[11:0] = instr[31:20];
            6'b001000: new_imm[11:0] = {instr[31:25], instr[11:7]};
            6'b000100: new_imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            6'b000010: new_imm[31:0] = {instr[31:12], 12'b0};
            6'b000001: new_imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: begin
                new_imm = '1;
                new_err = 1'b1;
            end
        endcase
    end

    // The skid entry is only ever filled while the output reg is held, so it always
    // drains into the output reg before any newer item can.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            immout     <= '0;
            imm_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_err   <= 1'b0;
        end else if (!out_valid || drain) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                immout     <= skid_imm;
                imm_err    <= skid_err;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                immout    <= new_imm;
                imm_err   <= new_err;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= new_imm;
            skid_err   <= new_err;
        end
    end

`ifdef IMM_ERR_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (accept && new_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: vector table, stall/stream/reset sequences, random traffic vs model.
// Build with IMM_ERR_CNT_EN defined to also check err_cnt.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [5:0]       ext_op;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  immout;
  logic             imm_err;
`ifdef IMM_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  imm_gen_pipe #(.XLEN(XLEN), .SHAMT_W(5), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .EXTOp    (ext_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .immout   (immout),
    .imm_err  (imm_err)
`ifdef IMM_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: immediate built arithmetically from the RV field definitions
  function automatic logic [32:0] ref_imm(input logic [31:0] ins, input logic [5:0] op);
    int v;
    logic [31:0] r;
    if ($countones(op) != 1) return {1'b1, 32'hFFFF_FFFF};
    if (op[5])      v = int'((ins >> 20) & 32'd31);
    else if (op[4]) v = int'($signed(ins) >>> 20);
    else if (op[3]) v = int'($signed(ins) >>> 25) * 32 + int'((ins >> 7) & 32'd31);
    else if (op[2]) v = (ins[31] ? -4096 : 0) + (ins[7] ? 2048 : 0)
                        + int'((ins >> 25) & 32'd63) * 32 + int'((ins >> 8) & 32'd15) * 2;
    else if (op[1]) v = int'(ins & 32'hFFFF_F000);
    else            v = (ins[31] ? -(1 << 20) : 0) + int'((ins >> 12) & 32'd255) * 4096
                        + (ins[20] ? 2048 : 0) + int'((ins >> 21) & 32'd1023) * 2;
    r = v;
    return {1'b0, r};
  endfunction

  // scoreboard
  logic [32:0] exp_q[$];
  int          drains    = 0;
  int          model_cnt = 0;
  logic        held      = 1'b0;
  logic [32:0] held_val;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      held      = 1'b0;
      model_cnt = 0;
    end else begin
      if (held) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data", {31'd0, imm_err, immout}, {31'd0, held_val});
      end
      held     = out_valid && !out_ready;
      held_val = {imm_err, immout};
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_imm(instr, ext_op));
        if ($countones(ext_op) != 1 && model_cnt < (1 << CNT_W) - 1) model_cnt++;
      end
      if (out_valid && out_ready) begin
        drains++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", {31'd0, imm_err, immout}, 64'd0);
        end else begin
          check("sb_order", {31'd0, imm_err, immout}, {31'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [5:0]  op;
    logic [31:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[10];
  int   d0;

  initial begin
    vecs[0] = '{"i_neg",   32'hFFF0_0093, 6'b010000, 32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{"i_pos",   32'h7FF0_0093, 6'b010000, 32'h0000_07FF, 1'b0};
    vecs[2] = '{"b_neg",   32'hFE00_0EE3, 6'b000100, 32'hFFFF_FFFC, 1'b0};
    vecs[3] = '{"u_fmt",   32'h1234_50B7, 6'b000010, 32'h1234_5000, 1'b0};
    vecs[4] = '{"j_fmt",   32'h0080_006F, 6'b000001, 32'h0000_0008, 1'b0};
    vecs[5] = '{"s_neg",   32'hFE11_2E23, 6'b001000, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{"shamt",   32'hFFFF_FFFF, 6'b100000, 32'h0000_001F, 1'b0};
    vecs[7] = '{"ill_0",   32'h1234_50B7, 6'b000000, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{"ill_2",   32'h0000_0013, 6'b110000, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{"ill_all", 32'h0000_0000, 6'b111111, 32'hFFFF_FFFF, 1'b1};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    ext_op    = '0;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_immout", {32'd0, immout}, 64'd0);
    check("rst_imm_err", {63'd0, imm_err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef IMM_ERR_CNT_EN
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
`endif
    step();
    step();
    rstn = 1'b1;
    idle(2);

    // table-driven vectors, one at a time, 1-cycle latency
    foreach (vecs[i]) begin
      in_valid = 1'b1;
      instr    = vecs[i].ins;
      ext_op   = vecs[i].op;
      step();
      in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
      check({vecs[i].name, "_imm"}, {32'd0, immout}, {32'd0, vecs[i].imm});
      check({vecs[i].name, "_err"}, {63'd0, imm_err}, {63'd0, vecs[i].err});
    end
    idle(2);
`ifdef IMM_ERR_CNT_EN
    check("err_cnt_table", {56'd0, err_cnt}, 64'd3);
`endif

    // stall: three items against a blocked consumer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h0010_0093; ext_op = 6'b010000;
    step();
    check("stall_in_ready_1", {63'd0, in_ready}, 64'd1);
    instr = 32'h0020_0093;
    step();
    check("stall_in_ready_full", {63'd0, in_ready}, 64'd0);
    instr = 32'h0030_0093;
    step();
    check("stall_still_full", {63'd0, in_ready}, 64'd0);
    check("stall_head", {32'd0, immout}, 64'd1);
    out_ready = 1'b1;
    step();
    check("release_second", {32'd0, immout}, 64'd2);
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("release_third", {32'd0, immout}, 64'd3);
    idle(3);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // streaming: 16 back-to-back beats, no bubbles
    d0 = drains;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      instr    = $urandom;
      ext_op   = 6'b000001 << $urandom_range(0, 5);
      step();
      check("stream_no_bubble", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_count", 64'(drains - d0), 64'd16);
    idle(2);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = $urandom;
      ext_op    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : (6'b000001 << $urandom_range(0, 5));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || out_valid); c++) step();
    check("random_drained", 64'(exp_q.size()), 64'd0);
`ifdef IMM_ERR_CNT_EN
    check("err_cnt_random", {56'd0, err_cnt}, 64'(model_cnt));
`endif

    // reset while output reg and skid are both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr = 32'h0000_0013; ext_op = 6'b000000;
    step();
    step();
    check("pre_reset_full", {63'd0, in_ready}, 64'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef IMM_ERR_CNT_EN
    check("reset_err_cnt", {56'd0, err_cnt}, 64'd0);
`endif
    in_valid = 1'b0;
    step();
    rstn = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_reset_no_replay", {63'd0, out_valid}, 64'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
